// File: rtl/mem_arb_pkg.sv
// Shared encodings and lane helpers for the two-port memory access arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_BYTES_DEF = 4096;
  localparam int unsigned WORD_W        = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  // Right-justified lane mask for a transfer size; shifted by the byte offset for merge/extract.
  function automatic logic [WORD_W-1:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: lane_mask = 32'h0000_00FF;
      SZ_HALF: lane_mask = 32'h0000_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone request wins; on a tie the port that did not win last goes.
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = rr_last ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares a word-organised data memory between two requesters with round-robin arbitration,
// access checking, and read-modify-write for sub-word stores.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned AW1 = ADDR_W + 1;

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [1:0]        grant;
  logic              win_q, win_d, we_q, we_d, fault_q, fault_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              sel_port, sel_we, sel_fault;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [4:0]        lane_shift;
  logic [DATA_W-1:0] lanes;
  logic [1:0]        ack_nxt, err_nxt;
  logic [DATA_W-1:0] rdata_nxt, mem_wdata_nxt;
  logic              mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;

  mem_arb_rr u_rr (
    .req    (req),
    .rr_last(rr_last_q),
    .grant_c(grant)
  );

  assign sel_port  = grant[1];
  assign sel_we    = we[sel_port];
  assign sel_size  = sel_port ? size1  : size0;
  assign sel_addr  = sel_port ? addr1  : addr0;
  assign sel_wdata = sel_port ? wdata1 : wdata0;

  // Illegal size, misalignment, or any byte of the access past the end of memory.
  always_comb begin
    sel_fault = 1'b0;
    if (sel_size == SZ_ILL) sel_fault = 1'b1;
    if (sel_size == SZ_HALF && sel_addr[0]) sel_fault = 1'b1;
    if (sel_size == SZ_WORD && sel_addr[1:0] != 2'b00) sel_fault = 1'b1;
    if ((AW1'({1'b0, sel_addr}) + AW1'(size_bytes(sel_size))) > AW1'(MEM_BYTES)) sel_fault = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      win_q     <= win_d;
      we_q      <= we_d;
      fault_q   <= fault_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    win_d     = win_q;
    we_d      = we_q;
    fault_d   = fault_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          rr_last_d = sel_port;
          win_d     = sel_port;
          we_d      = sel_we;
          fault_d   = sel_fault;
          size_d    = sel_size;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          if (sel_fault)              state_d = ST_RESP;
          else if (!sel_we)           state_d = ST_RD;
          else if (sel_size == SZ_WORD) state_d = ST_WR;
          else                        state_d = ST_RMW_RD;
        end
      end
      ST_RD, ST_WR, ST_RMW_WR: state_d = ST_RESP;
      ST_RMW_RD:               state_d = ST_RMW_WR;
      default:                 state_d = ST_IDLE;
    endcase
  end

  assign lane_shift = {addr_q[1:0], 3'b000};
  assign lanes      = DATA_W'(lane_mask(size_q)) << lane_shift;

  // Next values of the registered outputs, decoded from the state being entered.
  always_comb begin
    ack_nxt       = 2'b00;
    err_nxt       = 2'b00;
    rdata_nxt     = '0;
    mem_read_nxt  = (state_d == ST_RD) || (state_d == ST_RMW_RD);
    mem_write_nxt = (state_d == ST_WR) || (state_d == ST_RMW_WR);
    mem_addr_nxt  = '0;
    mem_wdata_nxt = '0;
    if (mem_read_nxt || mem_write_nxt) mem_addr_nxt = {addr_d[ADDR_W-1:2], 2'b00};
    if (state_d == ST_WR) mem_wdata_nxt = wdata_d;
    if (state_d == ST_RMW_WR) mem_wdata_nxt = (mem_rdata & ~lanes) | ((wdata_q << lane_shift) & lanes);
    if (state_d == ST_RESP) begin
      ack_nxt[win_d] = 1'b1;
      err_nxt[win_d] = fault_d;
      if (state_q == ST_RD) rdata_nxt = (mem_rdata >> lane_shift) & DATA_W'(lane_mask(size_q));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack       <= 2'b00;
      err       <= 2'b00;
      rdata     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack       <= ack_nxt;
      err       <= err_nxt;
      rdata     <= rdata_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: a byte-array reference model predicts
// error, load data and latency for directed and random transactions on both ports.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, size0, size1, ack, err;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  int overlap_cnt = 0;

  mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size0(size0), .size1(size1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory behind the arbiter, preloaded with a known pattern.
  logic [31:0] mem_words [1024];
  logic        preload = 1'b1;

  function automatic logic [31:0] init_word(input int i);
    return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'(i);
  endfunction

  assign mem_rdata = mem_words[mem_addr[11:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem_words[i] <= init_word(i);
    end else if (mem_write) begin
      mem_words[mem_addr[11:2]] <= mem_wdata;
    end
  end

  always @(negedge clk) if (mem_read && mem_write) overlap_cnt++;

  // Reference model: plain byte array with the access rules applied directly.
  logic [7:0] ref_mem [4096];

  task automatic ref_init();
    logic [31:0] w;
    for (int i = 0; i < 4096; i++) begin
      w = init_word(i / 4);
      ref_mem[i] = w[8*(i%4) +: 8];
    end
  endtask

  task automatic ref_apply(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output logic exp_err,
                           output logic [31:0] exp_rd, output int exp_lat);
    int nb;
    longint end_addr;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    end_addr = longint'(a) + longint'(nb);
    exp_err = (nb == 0) || ((a % nb) != 0) || (end_addr > 4096);
    exp_rd  = 32'h0;
    if (exp_err) exp_lat = 1;
    else if (!w) begin
      exp_lat = 2;
      for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = ref_mem[a + 32'(i)];
    end else begin
      exp_lat = (nb == 4) ? 2 : 3;
      for (int i = 0; i < nb; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    end
  endtask

  task automatic drive_port(input int p, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin we[0] = w; size0 = sz; addr0 = a; wdata0 = wd; end
    else        begin we[1] = w; size1 = sz; addr1 = a; wdata1 = wd; end
  endtask

  // Issues one request and reports what the arbiter did; latency 0 means no ack in budget.
  task automatic run_txn(input int p, input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [1:0] o_ack, output logic o_err,
                         output logic [31:0] o_rd, output int o_lat, output int o_strobes);
    @(posedge clk); #1;
    drive_port(p, w, sz, a, wd);
    req[p] = 1'b1;
    o_ack = 2'b00; o_err = 1'b0; o_rd = 32'h0; o_lat = 0; o_strobes = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_read || mem_write) o_strobes++;
      if (ack != 2'b00) begin
        o_ack = ack; o_err = err[p]; o_rd = rdata; o_lat = c;
        break;
      end
    end
    req[p] = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 2'b00;
    drive_port(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive_port(1, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    vectors++; if ({ack, err} !== 4'b0) begin miscompares++; $display("FAIL reset_ack_err got %b exp 0000", {ack, err}); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    vectors++; if ({mem_read, mem_write} !== 2'b00) begin miscompares++; $display("FAIL reset_strobes got %b exp 00", {mem_read, mem_write}); end
    vectors++; if ({mem_addr, mem_wdata} !== 64'h0) begin miscompares++; $display("FAIL reset_mem_bus got %h exp 0", {mem_addr, mem_wdata}); end
  endtask

  task automatic test_directed();
    logic [1:0] a_o; logic e_o; logic [31:0] r_o; int lat, stb;
    logic ee; logic [31:0] er; int el;
    ref_apply(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, ee, er, el);
    run_txn(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, a_o, e_o, r_o, lat, stb);
    vectors++; if ({a_o, e_o} !== 3'b010) begin miscompares++; $display("FAIL wstore_ack got %b/%b exp 01/0", a_o, e_o); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wstore_lat got %0d exp 2", lat); end
    ref_apply(1'b0, 2'd2, 32'h10, 32'h0, ee, er, el);
    run_txn(0, 1'b0, 2'd2, 32'h10, 32'h0, a_o, e_o, r_o, lat, stb);
    vectors++; if ({a_o, e_o, r_o} !== {2'b01, 1'b0, 32'hDEADBEEF}) begin miscompares++; $display("FAIL wload got %b/%b/%h exp 01/0/deadbeef", a_o, e_o, r_o); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wload_lat got %0d exp 2", lat); end
    ref_apply(1'b1, 2'd0, 32'h11, 32'hAA, ee, er, el);
    run_txn(1, 1'b1, 2'd0, 32'h11, 32'hAA, a_o, e_o, r_o, lat, stb);
    vectors++; if ({a_o, e_o} !== 3'b100) begin miscompares++; $display("FAIL bstore_ack got %b/%b exp 10/0", a_o, e_o); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL bstore_lat got %0d exp 3", lat); end
    ref_apply(1'b0, 2'd2, 32'h10, 32'h0, ee, er, el);
    run_txn(0, 1'b0, 2'd2, 32'h10, 32'h0, a_o, e_o, r_o, lat, stb);
    vectors++; if (r_o !== 32'hDEADAAEF) begin miscompares++; $display("FAIL merged_word got %h exp deadaaef", r_o); end
    run_txn(1, 1'b0, 2'd1, 32'h12, 32'h0, a_o, e_o, r_o, lat, stb);
    vectors++; if ({a_o, r_o} !== {2'b10, 32'h0000DEAD}) begin miscompares++; $display("FAIL half_load got %b/%h exp 10/0000dead", a_o, r_o); end
  endtask

  task automatic test_errors();
    logic [1:0] a_o; logic e_o; logic [31:0] r_o; int lat, stb;
    logic ee; logic [31:0] er; int el;
    logic        t_w  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  t_sz [6] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd0};
    logic [31:0] t_a  [6] = '{32'h13, 32'hFFF, 32'h1000, 32'h20, 32'hFFC, 32'hFFF};
    for (int k = 0; k < 6; k++) begin
      ref_apply(t_w[k], t_sz[k], t_a[k], 32'hC3C3_5A5A, ee, er, el);
      run_txn(k % 2, t_w[k], t_sz[k], t_a[k], 32'hC3C3_5A5A, a_o, e_o, r_o, lat, stb);
      vectors++; if ({a_o, e_o, r_o} !== {2'(1 << (k % 2)), ee, er}) begin miscompares++;
        $display("FAIL err_case[%0d] got %b/%b/%h exp %b/%b/%h", k, a_o, e_o, r_o, 2'(1 << (k % 2)), ee, er); end
      vectors++; if (lat !== el) begin miscompares++; $display("FAIL err_case_lat[%0d] got %0d exp %0d", k, lat, el); end
      if (ee) begin
        vectors++; if (stb !== 0) begin miscompares++; $display("FAIL err_case_strobes[%0d] got %0d exp 0", k, stb); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      ref_apply(1'b0, 2'd2, 32'h10 + 32'(k) * 32'hFEC, 32'h0, ee, er, el);
      run_txn(k, 1'b0, 2'd2, 32'h10 + 32'(k) * 32'hFEC, 32'h0, a_o, e_o, r_o, lat, stb);
      vectors++; if (r_o !== er) begin miscompares++; $display("FAIL err_mem_intact[%0d] got %h exp %h", k, r_o, er); end
    end
  endtask

  task automatic test_fairness();
    int order [4];
    int n = 0;
    logic [31:0] got_rd [4];
    logic [1:0] drop = 2'b00;
    logic ee; logic [31:0] er0, er1; int el;
    apply_reset();
    overlap_cnt = 0;
    ref_apply(1'b0, 2'd2, 32'h40, 32'h0, ee, er0, el);
    ref_apply(1'b0, 2'd2, 32'h80, 32'h0, ee, er1, el);
    @(posedge clk); #1;
    drive_port(0, 1'b0, 2'd2, 32'h40, 32'h0);
    drive_port(1, 1'b0, 2'd2, 32'h80, 32'h0);
    req = 2'b11;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (drop[p]) begin req[p] = 1'b1; drop[p] = 1'b0; end
      for (int p = 0; p < 2; p++) if (ack[p] && n < 4) begin
        order[n] = p; got_rd[n] = rdata; n++;
        req[p] = 1'b0; drop[p] = 1'b1;
      end
    end
    req = 2'b00;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL fair_count got %0d exp 4", n); end
    for (int k = 0; k < n; k++) begin
      vectors++; if (order[k] !== k % 2) begin miscompares++; $display("FAIL fair_order[%0d] got %0d exp %0d", k, order[k], k % 2); end
      vectors++; if (got_rd[k] !== ((k % 2) ? er1 : er0)) begin miscompares++; $display("FAIL fair_rdata[%0d] got %h", k, got_rd[k]); end
    end
    vectors++; if (overlap_cnt !== 0) begin miscompares++; $display("FAIL fair_overlap got %0d exp 0", overlap_cnt); end
  endtask

  task automatic test_reset_mid_rmw();
    logic [1:0] a_o; logic e_o; logic [31:0] r_o; int lat, stb;
    logic ee; logic [31:0] er; int el;
    int stray = 0;
    @(posedge clk); #1;
    drive_port(0, 1'b1, 2'd0, 32'h10, 32'h55);
    req[0] = 1'b1;
    @(posedge clk); #1;
    vectors++; if ({mem_read, mem_write, mem_addr} !== {2'b10, 32'h10}) begin miscompares++;
      $display("FAIL rmw_rd_phase got %b/%h exp 10/00000010", {mem_read, mem_write}, mem_addr); end
    rst = 1'b1; #1;
    vectors++; if ({ack, err, rdata, mem_read, mem_write, mem_addr, mem_wdata} !== 102'h0) begin miscompares++;
      $display("FAIL rst_mid_outputs got %h exp 0", {ack, err, rdata, mem_read, mem_write, mem_addr, mem_wdata}); end
    @(posedge clk); #1;
    req = 2'b00; rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack != 2'b00 || mem_write) stray++;
    end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL rst_mid_stray got %0d exp 0", stray); end
    ref_apply(1'b0, 2'd2, 32'h10, 32'h0, ee, er, el);
    run_txn(1, 1'b0, 2'd2, 32'h10, 32'h0, a_o, e_o, r_o, lat, stb);
    vectors++; if (r_o !== er) begin miscompares++; $display("FAIL rst_mid_word got %h exp %h", r_o, er); end
    ref_apply(1'b1, 2'd0, 32'h10, 32'h55, ee, er, el);
    run_txn(0, 1'b1, 2'd0, 32'h10, 32'h55, a_o, e_o, r_o, lat, stb);
    vectors++; if ({a_o, e_o, lat} !== {2'b01, 1'b0, 32'd3}) begin miscompares++; $display("FAIL post_rst_store got %b/%b/%0d exp 01/0/3", a_o, e_o, lat); end
    ref_apply(1'b0, 2'd2, 32'h10, 32'h0, ee, er, el);
    run_txn(0, 1'b0, 2'd2, 32'h10, 32'h0, a_o, e_o, r_o, lat, stb);
    vectors++; if (r_o !== er) begin miscompares++; $display("FAIL post_rst_word got %h exp %h", r_o, er); end
  endtask

  task automatic test_random();
    logic [1:0] a_o; logic e_o; logic [31:0] r_o; int lat, stb;
    logic ee; logic [31:0] er; int el;
    int p; logic w; logic [1:0] sz; logic [31:0] a, wd;
    overlap_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      p  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(32'hFF0, 32'h100F)) : 32'($urandom_range(0, 63));
      wd = $urandom;
      ref_apply(w, sz, a, wd, ee, er, el);
      run_txn(p, w, sz, a, wd, a_o, e_o, r_o, lat, stb);
      vectors++; if (a_o !== 2'(1 << p)) begin miscompares++; $display("FAIL rnd_ack[%0d] got %b exp %b", k, a_o, 2'(1 << p)); end
      vectors++; if (e_o !== ee) begin miscompares++; $display("FAIL rnd_err[%0d] addr %h sz %0d got %b exp %b", k, a, sz, e_o, ee); end
      vectors++; if (r_o !== er) begin miscompares++; $display("FAIL rnd_rdata[%0d] addr %h sz %0d got %h exp %h", k, a, sz, r_o, er); end
      vectors++; if (lat !== el) begin miscompares++; $display("FAIL rnd_lat[%0d] got %0d exp %0d", k, lat, el); end
    end
    vectors++; if (overlap_cnt !== 0) begin miscompares++; $display("FAIL rnd_overlap got %0d exp 0", overlap_cnt); end
  endtask

  initial begin
    ref_init();
    rst = 1'b1; req = 2'b00;
    drive_port(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive_port(1, 1'b0, 2'b00, 32'h0, 32'h0);
    test_reset();
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    apply_reset();
    test_directed();
    test_errors();
    test_fairness();
    test_reset_mid_rmw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
